// File: rtl/mac_row_feeder.sv
// -----------------------------------------------------------------------------
// mac_row_feeder
//   Upstream stage of the fixed-point MAC array. Holds a J x A binary selection
//   matrix M and, for each frame, pairs J incoming 32-bit samples with matrix
//   rows 0..J-1. The pair is emitted as two lockstep streams (vinput / M_row)
//   with tvalid and tlast (tlast on row J-1). One start command runs I frames,
//   then a one-cycle done pulse is issued. The MAC cannot stall, so every
//   output beat is unconditional once produced.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous active-high reset (clears state and matrix)
//   m_wr_en        matrix row write strobe (honoured only while idle)
//   m_wr_addr      row index to write (rows >= J are dropped)
//   m_wr_data      row contents, bit k = selection for MAC lane k
//   start          single-cycle command to begin I frames (ignored unless idle)
//   s_vin          upstream sample
//   s_vin_tvalid   upstream sample valid
//   s_vin_tready   feeder accepts a sample (high only while streaming)
//   vinput         sample to the MAC
//   vinput_tvalid  sample valid to the MAC
//   vinput_tlast   last row of the frame
//   M_row          matrix row aligned with vinput
//   M_row_tvalid   same as vinput_tvalid
//   M_row_tlast    same as vinput_tlast
//   busy           high while streaming or in the inter-frame gap
//   done           one-cycle pulse the cycle after the final output beat
//   frame_cnt      frames completed in the current run
// -----------------------------------------------------------------------------
module mac_row_feeder #(
  parameter int J = 14,
  parameter int A = 2,
  parameter int I = 7,
  localparam int J_WIDTH = $clog2(J) + 1,
  localparam int I_WIDTH = $clog2(I) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               m_wr_en,
  input  logic [J_WIDTH-1:0] m_wr_addr,
  input  logic [A-1:0]       m_wr_data,
  input  logic               start,
  input  logic [31:0]        s_vin,
  input  logic               s_vin_tvalid,
  output logic               s_vin_tready,
  output logic [31:0]        vinput,
  output logic               vinput_tvalid,
  output logic               vinput_tlast,
  output logic [A-1:0]       M_row,
  output logic               M_row_tvalid,
  output logic               M_row_tlast,
  output logic               busy,
  output logic               done,
  output logic [I_WIDTH-1:0] frame_cnt
);

  localparam logic [J_WIDTH-1:0] LAST_ROW = J_WIDTH'(J - 1);
  localparam logic [J_WIDTH-1:0] NUM_ROWS = J_WIDTH'(J);
  localparam logic [I_WIDTH-1:0] NUM_FRAMES = I_WIDTH'(I);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_GAP    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [J_WIDTH-1:0]   row_q, row_d;
  logic [I_WIDTH-1:0]   frame_q, frame_d;
  logic [A-1:0]         m_q [J];

  logic [31:0]          vin_q;
  logic [A-1:0]         mrow_q;
  logic                 tvalid_q;
  logic                 tlast_q;
  logic                 busy_q;
  logic                 done_q;

  logic                 xfer_s;
  logic                 last_row_s;
  logic                 wr_ok_s;
  logic [I_WIDTH-1:0]   frame_inc_s;
  logic [A-1:0]         row_sel_s;

  // Handshake and row bookkeeping helpers
  assign s_vin_tready = (state_q == ST_STREAM);
  assign xfer_s       = s_vin_tvalid && (state_q == ST_STREAM);
  assign last_row_s   = (row_q == LAST_ROW);
  assign frame_inc_s  = frame_q + I_WIDTH'(1);
  // Writes are only taken while idle so M cannot change under a running frame
  assign wr_ok_s      = m_wr_en && (state_q == ST_IDLE) && (m_wr_addr < NUM_ROWS);

  // Row select mux: AND-OR form keeps the index width independent of J
  always_comb begin
    row_sel_s = {A{1'b0}};
    for (int r = 0; r < J; r++) begin
      row_sel_s = row_sel_s | (m_q[r] & {A{row_q == J_WIDTH'(r)}});
    end
  end

  // Next-state, row counter and frame counter logic
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    frame_d = frame_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_STREAM;
          row_d   = {J_WIDTH{1'b0}};
          frame_d = {I_WIDTH{1'b0}};
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (xfer_s) begin
          if (last_row_s) begin
            row_d   = {J_WIDTH{1'b0}};
            frame_d = frame_inc_s;
            // Last frame skips the gap and goes straight to done
            if (frame_inc_s < NUM_FRAMES) begin
              state_d = ST_GAP;
            end else begin
              state_d = ST_DONE;
            end
          end else begin
            row_d = row_q + J_WIDTH'(1);
          end
        end else begin
          state_d = ST_STREAM;
        end
      end
      // One idle cycle so the accumulator can close its frame
      ST_GAP:  state_d = ST_STREAM;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, row and frame registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      row_q   <= {J_WIDTH{1'b0}};
      frame_q <= {I_WIDTH{1'b0}};
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      frame_q <= frame_d;
    end
  end

  // Selection matrix storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < J; r++) begin
        m_q[r] <= {A{1'b0}};
      end
    end else begin
      for (int r = 0; r < J; r++) begin
        if (wr_ok_s && (m_wr_addr == J_WIDTH'(r))) begin
          m_q[r] <= m_wr_data;
        end
      end
    end
  end

  // Output beat registers: data/row hold when no transfer, valid/last drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vin_q    <= 32'd0;
      mrow_q   <= {A{1'b0}};
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end else if (xfer_s) begin
      vin_q    <= s_vin;
      mrow_q   <= row_sel_s;
      tvalid_q <= 1'b1;
      tlast_q  <= last_row_s;
    end else begin
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
    end
  end

  // Status registers; done fires the cycle after DONE so it trails the last beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_STREAM) || (state_d == ST_GAP);
      done_q <= (state_q == ST_DONE);
    end
  end

  assign vinput        = vin_q;
  assign vinput_tvalid = tvalid_q;
  assign vinput_tlast  = tlast_q;
  assign M_row         = mrow_q;
  assign M_row_tvalid  = tvalid_q;
  assign M_row_tlast   = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign frame_cnt     = frame_q;

endmodule

// File: tb/tb_mac_row_feeder.sv
// -----------------------------------------------------------------------------
// tb_mac_row_feeder
//   Scoreboard bench for mac_row_feeder: each accepted sample pushes the
//   expected beat (sample, matrix row, tlast) and the beat is popped and
//   compared one cycle later. A small phase model predicts tready, busy,
//   done and frame_cnt every cycle.
// -----------------------------------------------------------------------------
module tb_mac_row_feeder;

  localparam int J  = 14;
  localparam int A  = 2;
  localparam int I  = 7;
  localparam int JW = $clog2(J) + 1;
  localparam int IW = $clog2(I) + 1;
  localparam int BUDGET = 600;

  localparam int P_IDLE   = 0;
  localparam int P_STREAM = 1;
  localparam int P_GAP    = 2;
  localparam int P_DONE   = 3;

  typedef struct packed {
    logic [31:0]  data;
    logic [A-1:0] row;
    logic         last;
  } beat_t;

  logic          clk;
  logic          rst;
  logic          m_wr_en;
  logic [JW-1:0] m_wr_addr;
  logic [A-1:0]  m_wr_data;
  logic          start;
  logic [31:0]   s_vin;
  logic          s_vin_tvalid;
  logic          s_vin_tready;
  logic [31:0]   vinput;
  logic          vinput_tvalid;
  logic          vinput_tlast;
  logic [A-1:0]  M_row;
  logic          M_row_tvalid;
  logic          M_row_tlast;
  logic          busy;
  logic          done;
  logic [IW-1:0] frame_cnt;

  int            checks = 0;
  int            errors = 0;
  beat_t         sb[$];
  logic [A-1:0]  m_model [J];
  int            exp_frames;
  logic [31:0]   last_data;
  logic [A-1:0]  last_row;

  mac_row_feeder #(.J(J), .A(A), .I(I)) dut (
    .clk          (clk),
    .rst          (rst),
    .m_wr_en      (m_wr_en),
    .m_wr_addr    (m_wr_addr),
    .m_wr_data    (m_wr_data),
    .start        (start),
    .s_vin        (s_vin),
    .s_vin_tvalid (s_vin_tvalid),
    .s_vin_tready (s_vin_tready),
    .vinput       (vinput),
    .vinput_tvalid(vinput_tvalid),
    .vinput_tlast (vinput_tlast),
    .M_row        (M_row),
    .M_row_tvalid (M_row_tvalid),
    .M_row_tlast  (M_row_tlast),
    .busy         (busy),
    .done         (done),
    .frame_cnt    (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_cleared(input string tag);
    check_val({tag, "_vinput"}, vinput, 0);
    check_val({tag, "_vtvalid"}, vinput_tvalid, 0);
    check_val({tag, "_vtlast"}, vinput_tlast, 0);
    check_val({tag, "_mrow"}, M_row, 0);
    check_val({tag, "_mtvalid"}, M_row_tvalid, 0);
    check_val({tag, "_mtlast"}, M_row_tlast, 0);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_frame_cnt"}, frame_cnt, 0);
    check_val({tag, "_tready"}, s_vin_tready, 0);
  endtask

  // Idle-time row write; the model only keeps in-range rows
  task automatic wr_row(input int addr, input logic [A-1:0] data);
    m_wr_en   = 1'b1;
    m_wr_addr = JW'(addr);
    m_wr_data = data;
    if (addr < J) m_model[addr] = data;
    @(negedge clk);
    m_wr_en = 1'b0;
  endtask

  task automatic clear_model();
    for (int r = 0; r < J; r++) m_model[r] = '0;
    exp_frames = 0;
    last_data  = '0;
    last_row   = '0;
    sb.delete();
  endtask

  // One start command followed by cycle-by-cycle checking until done
  task automatic do_run(input string name, input int gap_pct, input int mid_cycle,
                        input bit rst_mid, input bit wr_with_start);
    int    mph;
    int    row;
    int    beats;
    int    lasts;
    bit    pending;
    bit    done_exp;
    bit    xfer;
    bit    fin;
    bit    valid;
    logic [31:0] sample;
    beat_t exp;
    mph = P_IDLE; row = 0; beats = 0; lasts = 0;
    pending = 0; done_exp = 0; fin = 0; sample = '0;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      check_val({name, "_vtvalid"}, vinput_tvalid, pending);
      check_val({name, "_mtvalid"}, M_row_tvalid, pending);
      if (pending) begin
        exp = sb.pop_front();
        check_val({name, "_vinput"}, vinput, exp.data);
        check_val({name, "_mrow"}, M_row, exp.row);
        check_val({name, "_vtlast"}, vinput_tlast, exp.last);
        check_val({name, "_mtlast"}, M_row_tlast, exp.last);
        last_data = exp.data;
        last_row  = exp.row;
      end else begin
        check_val({name, "_hold_vinput"}, vinput, last_data);
        check_val({name, "_hold_mrow"}, M_row, last_row);
      end
      check_val({name, "_done"}, done, done_exp);
      check_val({name, "_busy"}, busy, (mph == P_STREAM) || (mph == P_GAP));
      check_val({name, "_tready"}, s_vin_tready, mph == P_STREAM);
      check_val({name, "_frame_cnt"}, frame_cnt, exp_frames);
      if (done_exp) begin
        fin = 1;
        break;
      end
      if (rst_mid && mph == P_STREAM && exp_frames == 3 && row == 5) begin
        rst = 1'b1;
        s_vin_tvalid = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check_cleared({name, "_rst"});
        rst = 1'b0;
        clear_model();
        return;
      end
      // drive this cycle's inputs
      start = (cyc == 0) || (cyc == mid_cycle);
      if (cyc == 0 && wr_with_start) begin
        m_wr_en = 1'b1; m_wr_addr = '0; m_wr_data = 2'b11;
        m_model[0] = 2'b11;
      end else if (cyc == mid_cycle) begin
        m_wr_en = 1'b1; m_wr_addr = JW'(1); m_wr_data = ~m_model[1];
      end else begin
        m_wr_en = 1'b0;
      end
      valid = ($urandom_range(99) >= gap_pct);
      s_vin_tvalid = valid;
      s_vin = valid ? sample : $urandom;
      xfer = valid && s_vin_tready;
      pending  = xfer;
      done_exp = (mph == P_DONE);
      case (mph)
        P_IDLE: if (start) begin mph = P_STREAM; row = 0; exp_frames = 0; end
        P_STREAM: if (xfer) begin
          sb.push_back('{data: sample, row: m_model[row], last: (row == J - 1)});
          beats++;
          sample++;
          if (row == J - 1) begin
            lasts++;
            row = 0;
            exp_frames++;
            mph = (exp_frames < I) ? P_GAP : P_DONE;
          end else begin
            row++;
          end
        end
        P_GAP:   mph = P_STREAM;
        default: mph = P_IDLE;
      endcase
      @(negedge clk);
    end
    start = 1'b0; m_wr_en = 1'b0; s_vin_tvalid = 1'b0;
    if (!fin) check_val({name, "_timeout"}, 0, 1);
    check_val({name, "_beats"}, beats, J * I);
    check_val({name, "_lasts"}, lasts, I);
    @(negedge clk);
    check_val({name, "_done_once"}, done, 0);
    check_val({name, "_frame_cnt_after"}, frame_cnt, I);
    check_val({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    rst = 1'b1; m_wr_en = 1'b0; m_wr_addr = '0; m_wr_data = '0;
    start = 1'b0; s_vin = '0; s_vin_tvalid = 1'b0;
    clear_model();
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;
    @(negedge clk);

    // even rows select lane 1 only, odd rows lane 0 only: first beat 2'b10
    for (int r = 0; r < J; r++) wr_row(r, {~r[0], r[0]});
    do_run("run_full", 0, -1, 1'b0, 1'b0);

    do_run("run_gaps", 30, -1, 1'b0, 1'b0);

    // out-of-range address is dropped; mid-run write and start are ignored
    wr_row(14, 2'b11);
    wr_row(31, 2'b11);
    do_run("run_midcmd", 10, 40, 1'b0, 1'b0);
    do_run("run_readback", 0, -1, 1'b0, 1'b0);

    do_run("run_rst", 0, -1, 1'b1, 1'b0);

    // matrix cleared by reset, except row 0 written in the start cycle
    do_run("run_after_rst", 20, -1, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
